// File: rtl/framebuffer_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | framebuffer_arbiter : scanout/CPU arbiter for a single-port 320x240x8 RAM |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module framebuffer_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int FB_WORDS   = 76800,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_scan_req,
  input  logic [ADDR_WIDTH-1:0] i_scan_addr,
  output logic                  o_scan_gnt,
  output logic [7:0]            o_scan_data,
  output logic                  o_scan_valid,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [7:0]            i_cpu_wdata,
  output logic                  o_cpu_gnt,
  output logic [7:0]            o_cpu_rdata,
  output logic                  o_cpu_rvalid,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [7:0]            o_mem_wdata,
  input  logic [7:0]            i_mem_rdata
);

  localparam logic [0:0] c_st_normal = 1'b0;
  localparam logic [0:0] c_st_force  = 1'b1;

  localparam logic [7:0]            c_max_wait = 8'(MAX_WAIT);
  localparam logic [ADDR_WIDTH-1:0] c_fb_words = ADDR_WIDTH'(FB_WORDS);

  logic [0:0]            r_state;
  logic [7:0]            r_wait_cnt;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic                  r_rd_scan;
  logic                  r_rd_cpu;
  logic                  r_rd_in_range;
  logic [7:0]            r_scan_data;
  logic [7:0]            r_cpu_data;

  logic                  w_force;
  logic                  w_scan_gnt;
  logic                  w_cpu_gnt;
  logic                  w_scan_in_range;
  logic                  w_cpu_in_range;
  logic [7:0]            w_wait_nxt;
  logic [0:0]            w_state_nxt;
  logic [7:0]            w_rd_data;

  // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    w_force    = (r_state == c_st_force);
    w_scan_gnt = rst_n & i_scan_req & ~w_force;
    w_cpu_gnt  = rst_n & i_cpu_req & (w_force | ~i_scan_req);
  end

  always_comb begin
    w_scan_in_range = (i_scan_addr < c_fb_words);
    w_cpu_in_range  = (i_cpu_addr < c_fb_words);
  end

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!i_cpu_req || w_cpu_gnt) begin
      w_wait_nxt = 8'd0;
    end else if (r_wait_cnt < c_max_wait) begin
      w_wait_nxt = r_wait_cnt + 8'd1;
    end
  end

  // A FORCE slot is always consumed by the CPU, so it never lasts two cycles.
  always_comb begin
    w_state_nxt = c_st_normal;
    if (!w_force && (w_wait_nxt == c_max_wait)) begin
      w_state_nxt = c_st_force;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_normal;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    if (w_cpu_gnt) begin
      o_mem_addr = i_cpu_addr;
    end else if (w_scan_gnt) begin
      o_mem_addr = i_scan_addr;
    end else begin
      o_mem_addr = r_last_addr;
    end
    o_mem_we    = w_cpu_gnt & i_cpu_we & w_cpu_in_range;
    o_mem_wdata = i_cpu_wdata;
    o_scan_gnt  = w_scan_gnt;
    o_cpu_gnt   = w_cpu_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_addr <= '0;
    end else if (w_cpu_gnt || w_scan_gnt) begin
      r_last_addr <= o_mem_addr;
    end
  end

  // Read tag: who owns the RAM output next cycle and whether it is real data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_scan     <= 1'b0;
      r_rd_cpu      <= 1'b0;
      r_rd_in_range <= 1'b0;
    end else begin
      r_rd_scan     <= w_scan_gnt;
      r_rd_cpu      <= w_cpu_gnt & ~i_cpu_we;
      r_rd_in_range <= w_scan_gnt ? w_scan_in_range : w_cpu_in_range;
    end
  end

  assign w_rd_data = r_rd_in_range ? i_mem_rdata : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_data <= 8'h00;
      r_cpu_data  <= 8'h00;
    end else begin
      if (r_rd_scan) begin
        r_scan_data <= w_rd_data;
      end
      if (r_rd_cpu) begin
        r_cpu_data <= w_rd_data;
      end
    end
  end

  // RAM data bypasses the hold register during the valid cycle itself.
  always_comb begin
    o_scan_valid = r_rd_scan;
    o_cpu_rvalid = r_rd_cpu;
    o_scan_data  = r_rd_scan ? w_rd_data : r_scan_data;
    o_cpu_rdata  = r_rd_cpu ? w_rd_data : r_cpu_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_arbiter.sv
`default_nettype none
// Bench for framebuffer_arbiter: directed steps plus random traffic against a
// cycle-level reference model and a write-first RAM.
module tb_framebuffer_arbiter;
  localparam int AW = 17;
  localparam int FB = 76800;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          scan_req, scan_gnt, scan_valid;
  logic [AW-1:0] scan_addr;
  logic [7:0]    scan_data;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata, cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata, mem_rdata;

  framebuffer_arbiter #(.ADDR_WIDTH(AW), .FB_WORDS(FB), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_scan_req(scan_req), .i_scan_addr(scan_addr), .o_scan_gnt(scan_gnt),
    .o_scan_data(scan_data), .o_scan_valid(scan_valid),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_gnt(cpu_gnt), .o_cpu_rdata(cpu_rdata),
    .o_cpu_rvalid(cpu_rvalid), .o_mem_addr(mem_addr), .o_mem_we(mem_we),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
  end

  // Reference model state
  logic [7:0]    exp_mem [0:(1<<AW)-1];
  int            m_wait;
  bit            m_ps, m_pc;
  logic [7:0]    m_pd, m_sh, m_ch;
  logic [AW-1:0] m_last;
  bit            e_sg, e_cg;
  logic          obs_sg, obs_cg;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_ps = 0; m_pc = 0;
    m_pd = 8'h00; m_sh = 8'h00; m_ch = 8'h00; m_last = '0;
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step(input bit sr, input logic [AW-1:0] sa, input bit cr,
                      input bit cw, input logic [AW-1:0] ca, input logic [7:0] cd);
    bit            starved;
    bit            ewe;
    logic [AW-1:0] ea;
    scan_req = sr; scan_addr = sa;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    #1;
    starved = (m_wait >= MW);
    e_cg    = cr && (starved || !sr);
    e_sg    = sr && !starved;
    ea      = e_cg ? ca : (e_sg ? sa : m_last);
    ewe     = e_cg && cw && (int'(ca) < FB);
    obs_sg  = scan_gnt;
    obs_cg  = cpu_gnt;
    chk("scan_gnt", scan_gnt, e_sg);
    chk("cpu_gnt", cpu_gnt, e_cg);
    chk("mem_addr", mem_addr, ea);
    chk("mem_we", mem_we, ewe);
    if (ewe) chk("mem_wdata", mem_wdata, cd);
    chk("scan_valid", scan_valid, m_ps);
    chk("scan_data", scan_data, m_ps ? m_pd : m_sh);
    chk("cpu_rvalid", cpu_rvalid, m_pc);
    chk("cpu_rdata", cpu_rdata, m_pc ? m_pd : m_ch);
    @(posedge clk); #1;
    if (m_ps) m_sh = m_pd;
    if (m_pc) m_ch = m_pd;
    m_ps = e_sg;
    m_pc = e_cg && !cw;
    if (e_sg)      m_pd = (int'(sa) < FB) ? exp_mem[sa] : 8'h00;
    else if (m_pc) m_pd = (int'(ca) < FB) ? exp_mem[ca] : 8'h00;
    if (ewe) exp_mem[ca] = cd;
    if (e_cg || !cr)     m_wait = 0;
    else if (m_wait < MW) m_wait++;
    if (e_cg || e_sg) m_last = ea;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, 8'h00);
  endtask

  // Scan and CPU contend; count scan grants before the CPU gets in.
  task automatic starve_check(input string tag);
    int nscan;
    bit got;
    nscan = 0; got = 0;
    for (int i = 0; i < MW + 4 && !got; i++) begin
      step(1'b1, AW'(i % 10), 1'b1, 1'b0, AW'(7), 8'h00);
      if (obs_cg === 1'b1) got = 1;
      else if (obs_sg === 1'b1) nscan++;
    end
    chk(tag, nscan, MW);
    step(1'b1, AW'(3), 1'b0, 1'b0, '0, 8'h00);
    chk({tag, "_resume"}, obs_sg, 1'b1);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return AW'(FB + int'($urandom_range(0, 3)));
    return AW'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [AW-1:0] rsa, rca;
    bit            rsr, rcr, rcw;
    logic [7:0]    rcd;

    rst_n = 1'b0;
    scan_req = 1'b1; scan_addr = '0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(3); cpu_wdata = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_scan_gnt", scan_gnt, 1'b0);
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_scan_valid", scan_valid, 1'b0);
    chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst_scan_data", scan_data, 8'h00);
    chk("rst_cpu_rdata", cpu_rdata, 8'h00);
    rst_n = 1'b1;
    model_reset();
    idle();

    // CPU write then read of address 100
    step(1'b0, '0, 1'b1, 1'b1, AW'(100), 8'hA5);
    step(1'b0, '0, 1'b1, 1'b0, AW'(100), 8'h00);
    chk("rd100_valid", cpu_rvalid, 1'b1);
    chk("rd100_data", cpu_rdata, 8'hA5);
    idle();

    // Preload 0..31 with their own index, then stream scan reads 0..9
    for (int i = 0; i < 32; i++) step(1'b0, '0, 1'b1, 1'b1, AW'(i), 8'(i));
    for (int i = 0; i < 10; i++) step(1'b1, AW'(i), 1'b0, 1'b0, '0, 8'h00);
    idle();

    starve_check("starve_len");

    // Out-of-range write is dropped, read returns zero
    step(1'b0, '0, 1'b1, 1'b1, AW'(FB), 8'hFF);
    step(1'b0, '0, 1'b1, 1'b0, AW'(FB), 8'h00);
    chk("oob_valid", cpu_rvalid, 1'b1);
    chk("oob_data", cpu_rdata, 8'h00);
    idle();

    // Write followed immediately by scan read of the same address
    step(1'b0, '0, 1'b1, 1'b1, AW'(5), 8'h3C);
    step(1'b1, AW'(5), 1'b0, 1'b0, '0, 8'h00);
    chk("wf_valid", scan_valid, 1'b1);
    chk("wf_data", scan_data, 8'h3C);
    idle();

    // Reset lands between a CPU read grant and its data return
    scan_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(100);
    #1;
    chk("mrst_gnt", cpu_gnt, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mrst_gnt_off", cpu_gnt, 1'b0);
    @(posedge clk); #1;
    chk("mrst_rvalid", cpu_rvalid, 1'b0);
    chk("mrst_rdata", cpu_rdata, 8'h00);
    cpu_req = 1'b0;
    rst_n = 1'b1;
    model_reset();
    idle();
    starve_check("starve_after_rst");

    // Random traffic; requests hold their fields until granted
    rsr = 0; rcr = 0; rsa = '0; rca = '0; rcw = 0; rcd = 8'h00;
    repeat (400) begin
      if (!rsr) begin
        rsr = ($urandom_range(0, 99) < 60);
        rsa = rand_addr();
      end
      if (!rcr) begin
        rcr = ($urandom_range(0, 99) < 50);
        rcw = 1'($urandom_range(0, 1));
        rca = rand_addr();
        rcd = 8'($urandom);
      end
      step(rsr, rsa, rcr, rcw, rca, rcd);
      if (e_sg) rsr = 0;
      if (e_cg) rcr = 0;
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/framebuffer_arbiter.md
Name: framebuffer_arbiter

Overview:
- Shares the single-port 320x240x8 framebuffer RAM between two requesters: the VGA scanout reader and the CPU load/store port.
- Scanout has priority. A starvation counter guarantees the CPU a slot within a bounded number of cycles.
- Sits between the CPU memory-mapped framebuffer window, the pixel fetch logic, and the framebuffer RAM. All logic runs on one clock.

Parameters:
- AddrWidth, 17, framebuffer word address width.
- FbWords, 76800, number of valid framebuffer bytes (320*240).
- MaxWait, 8, cycles a pending CPU request may be refused before a grant is forced (range 1..255).

Ports:
- Clock  input  1  single system clock; all logic on its rising edge.
- ResetN  input  1  reset, asynchronous and active-low.
- ScanReq  input  1  scanout read request; held until granted.
- ScanAddr  input  AddrWidth  scanout pixel address.
- ScanGnt  output  1  scanout request accepted this cycle.
- ScanData  output  8  scanout read data.
- ScanValid  output  1  ScanData valid; one cycle after ScanGnt.
- CpuReq  input  1  CPU access request; held, with stable fields, until granted.
- CpuWe  input  1  1 = write, 0 = read.
- CpuAddr  input  AddrWidth  CPU byte address within the framebuffer.
- CpuWData  input  8  CPU write data.
- CpuGnt  output  1  CPU request accepted this cycle.
- CpuRData  output  8  CPU read data.
- CpuRValid  output  1  CpuRData valid; one cycle after a granted CPU read.
- MemAddr  output  AddrWidth  RAM address.
- MemWe  output  1  RAM write enable.
- MemWData  output  8  RAM write data.
- MemRData  input  8  RAM read data; 1-cycle latency after MemAddr.

Behaviour:
- Reset (ResetN low, asynchronous):
  - WaitCnt=0, state=NORMAL.
  - ScanValid=0, CpuRValid=0, ScanData=0, CpuRData=0.
  - ScanGnt, CpuGnt and MemWe forced 0 while ResetN is low.
- Grant is combinational within the cycle of the request; at most one grant per cycle; MemAddr/MemWe/MemWData are driven from the granted requester.
- State NORMAL:
  - ScanReq=1 -> ScanGnt.
  - Else CpuReq=1 -> CpuGnt.
  - If CpuReq=1 and CpuGnt=0, WaitCnt increments (saturating at MaxWait).
  - When WaitCnt reaches MaxWait, next state is FORCE.
- State FORCE:
  - CpuGnt=1 unconditionally; ScanGnt=0 even if ScanReq=1, and scanout must hold its request.
  - Next state is NORMAL, WaitCnt=0.
- Any CpuGnt clears WaitCnt. If CpuReq drops (not permitted, but tolerated), WaitCnt clears.
- Idle (no grant): MemWe=0, MemAddr holds its last value.
- Address range:
  - Address >= FbWords is still granted.
  - Writes are dropped (MemWe=0).
  - Reads return 8'h00 with the normal valid timing.
- Read return:
  - A registered tag records which requester was granted a read and whether the address was in range.
  - On the next cycle, ScanData or CpuRData is loaded from MemRData (or 0 if out of range) and the matching valid pulses for exactly 1 cycle.
  - The data registers hold their value until the next valid.
- A CPU write produces no CpuRValid.
- Back-to-back accesses: one grant per cycle, full throughput. A write at cycle N followed by a read of the same address at cycle N+1 returns the new data (RAM write-first behaviour).
- Reset asserted mid-read clears any pending valid; no stale ScanValid/CpuRValid after release.
- Latency:
  - Grant 0 cycles.
  - Read data 1 cycle after grant.
  - Worst-case CPU wait MaxWait cycles, with the grant on cycle MaxWait+1.

Test Plan:
- Reset, then CpuReq=1, CpuWe=1, CpuAddr=100, CpuWData=8'hA5 with ScanReq=0 -> CpuGnt same cycle, MemWe=1, MemAddr=100. Then a CPU read of 100 -> CpuRValid one cycle later, CpuRData=8'hA5.
- ScanReq=1 and CpuReq=1 in the same cycle (MaxWait=8) -> ScanGnt for 8 cycles. On the 9th cycle CpuGnt=1 and ScanGnt=0, then ScanGnt resumes and WaitCnt=0.
- Continuous scan reads of addresses 0..9 preloaded with values 0..9 -> ScanGnt every cycle; ScanValid every cycle from cycle 1 with ScanData 0..9 in order; CpuRValid never asserts.
- CPU write to address 76800 with data 8'hFF -> CpuGnt=1, MemWe=0. CPU read of 76800 -> CpuRData=0 with CpuRValid one cycle later.
- CPU write 8'h3C to address 5 at cycle N, scan read of 5 at cycle N+1 -> ScanData=8'h3C at N+2.
- Grant a CPU read, assert ResetN=0 before the next edge -> CpuRValid stays 0. After release all outputs match their reset values and WaitCnt=0.
